alu_md_control: RTL and testbench
=================================

Name: alu_md_control

Overview:
- Parametrised successor to the combinational ALU decoder.
- Decodes `ALUOp`/`Funct` into the 3-bit `ALUControl` with an extended R-type set.
- Adds an iterative multiply/divide unit with HI/LO registers and a busy/stall handshake to the control path.
- Sits between the main control decoder and the datapath. The core stalls on `md_stall` and selects `md_result` when `mf_sel` is high.

Parameters:
- WIDTH, 32, datapath width; operands, HI, LO and `md_result` are WIDTH bits.
- MD_EN, 1, 1 = mult/div/mfhi/mflo supported; 0 = those Funct codes decode as illegal and the FSM never leaves IDLE.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  current decode-stage instruction is valid
- ALUOp  in  2  from main decoder
- Funct  in  6  instruction bits [5:0]
- src_a  in  WIDTH  rs operand
- src_b  in  WIDTH  rt operand
- ALUControl  out  3  ALU operation select (combinational)
- illegal  out  1  unrecognised R-type Funct (combinational)
- mf_sel  out  1  MFHI/MFLO: writeback takes `md_result`
- md_result  out  WIDTH  HI for MFHI, LO otherwise
- md_stall  out  1  core must hold the current instruction (combinational)
- md_busy  out  1  iteration in progress (registered)
- md_done  out  1  one-cycle pulse: HI/LO just updated
- div_zero  out  1  one-cycle pulse with `md_done` for a divide by zero
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Decode of `ALUOp` (combinational):
  - 00 -> 010 (add)
  - 01 -> 110 (sub)
  - 11 -> 001 (or, for ori)
  - 10 -> R-type on `Funct`:
    - 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111
    - 100110 (XOR) -> 011; 100111 (NOR) -> 100; 101011 (SLTU) -> 101
    - Mult/div codes: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU. Move codes: 010000 MFHI, 010010 MFLO. All six drive `ALUControl` = 010 with `illegal` = 0.
    - Any other Funct: `ALUControl` = 010, `illegal` = 1. Never X.
- `mf_sel` = `instr_valid` & R-type & Funct is MFHI/MFLO.
- `md_stall` = `instr_valid` & R-type & Funct in {mult/div, MFHI, MFLO} & state != IDLE.
- Accept: on an edge where state = IDLE, `instr_valid`, R-type and Funct is a mult/div code:
  - capture |`src_a`|, |`src_b`| (signed ops only), the result signs, the op and the original `src_a`;
  - enter MUL or DIV.
- FSM states: IDLE, MUL, DIV, FIX.
- MUL: one shift-add step per cycle for WIDTH cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle for WIDTH cycles, then FIX.
- FIX:
  - apply signs: product negated if sign_a ^ sign_b; quotient sign = sign_a ^ sign_b; remainder sign = sign_a;
  - write HI/LO and pulse `md_done`;
  - return to IDLE.
- Results:
  - MULT/MULTU: HI:LO = 2·WIDTH-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Latency:
  - Accept at edge k. `md_busy` is high after edge k through the FIX cycle.
  - HI/LO update and `md_done` = 1 are visible after edge k+WIDTH+1. `md_busy` = 0 in the same cycle.
  - An MFHI/MFLO stalled behind the op proceeds in that cycle.
- Divide by zero (`src_b` = 0 at accept):
  - skip iteration, accept -> FIX directly (done after edge k+1);
  - LO = all ones, HI = original `src_a`, `div_zero` pulses with `md_done`.
- DIV of MIN by -1: LO = MIN (wraps), HI = 0, no flag.
- A mult/div presented while busy is not accepted; it is stalled and accepted in the first IDLE cycle.
- `md_result` reads the current HI/LO registers (post-update value once `md_done` is visible).
- MD_EN = 0: `md_busy`, `md_done` and `div_zero` are tied 0; `hi` and `lo` hold 0.
- Reset (`rst_n` low, asynchronous, any time including mid-operation):
  - state = IDLE, iteration aborted;
  - `hi` = 0, `lo` = 0, `md_busy` = 0, `md_done` = 0, `div_zero` = 0;
  - operand and iteration registers = 0.

Test Plan:
- Decode sweep: all `ALUOp` values and all 64 Funct codes with ALUOp=10 -> codes per table; `illegal` = 1 on undefined codes; no X on any output.
- MULT with `src_a` = 0xFFFFFFFD, `src_b` = 7, accepted at edge k -> `md_done` after edge k+33, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULTU with the same operands -> HI = 0x00000006, LO = 0xFFFFFFEB.
- DIV with `src_a` = 0xFFFFFFF9 (-7), `src_b` = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100/7 -> LO = 14, HI = 2. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIV with `src_a` = 0x1234, `src_b` = 0 -> `md_done` and `div_zero` after edge k+1; LO = 0xFFFFFFFF, HI = 0x1234.
- MFLO issued one cycle after a MULT accept -> `md_stall` = 1 for WIDTH+1 cycles; then `mf_sel` = 1 and `md_result` = new LO in the `md_done` cycle. A second MULT issued mid-op is held the same way.
- Assert `rst_n` low at iteration 10 of a MULT -> `md_busy`, `hi` and `lo` clear immediately. After release, a fresh DIVU 9/3 completes with LO = 3, HI = 0.

Source files
------------

// File: rtl/alu_md_control.sv
// ALU control decoder with an iterative multiply/divide unit and HI/LO registers.
// The core stalls on md_stall and selects md_result for MFHI/MFLO when mf_sel is high.
module alu_md_control #(
  parameter int unsigned WIDTH = 32,
  parameter bit          MD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic             mf_sel,
  output logic [WIDTH-1:0] md_result,
  output logic             md_stall,
  output logic             md_busy,
  output logic             md_done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam int unsigned      CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     orig_a_q;
  logic                 sa_q;
  logic                 neg_q;
  logic                 div_q;
  logic                 zero_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 divz_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 is_md;
  logic                 is_mf;
  logic                 rtype;
  logic                 accept;
  logic                 signed_op;
  logic                 div_op;
  logic                 b_zero;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_acc_d;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   div_acc_d;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  // Operation decode; unknown codes fall back to add so ALUControl is never X.
  always_comb begin
    ALUControl = 3'b010;
    illegal    = 1'b0;
    is_md      = 1'b0;
    is_mf      = 1'b0;
    case (ALUOp)
      2'b00: ALUControl = 3'b010;
      2'b01: ALUControl = 3'b110;
      2'b11: ALUControl = 3'b001;
      default: begin
        case (Funct)
          F_ADD:  ALUControl = 3'b010;
          F_SUB:  ALUControl = 3'b110;
          F_AND:  ALUControl = 3'b000;
          F_OR:   ALUControl = 3'b001;
          F_SLT:  ALUControl = 3'b111;
          F_XOR:  ALUControl = 3'b011;
          F_NOR:  ALUControl = 3'b100;
          F_SLTU: ALUControl = 3'b101;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            is_md   = MD_EN;
            illegal = ~MD_EN;
          end
          F_MFHI, F_MFLO: begin
            is_mf   = MD_EN;
            illegal = ~MD_EN;
          end
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign rtype     = (ALUOp == 2'b10);
  assign mf_sel    = instr_valid & rtype & is_mf;
  assign md_stall  = instr_valid & rtype & (is_md | is_mf) & (state_q != S_IDLE);
  assign accept    = instr_valid & rtype & is_md & (state_q == S_IDLE);
  assign md_result = (Funct == F_MFHI) ? hi_q : lo_q;

  assign signed_op = ~Funct[0];
  assign div_op    = Funct[1];
  assign b_zero    = (src_b == '0);
  assign abs_a     = (signed_op & src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b     = (signed_op & src_b[WIDTH-1]) ? -src_b : src_b;

  // Shift-add: upper half accumulates, multiplier shifts out of the lower half.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
  assign mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: {remainder, dividend/quotient} shifts left one bit per step.
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mcand_q};
  assign div_acc_d = div_trial[WIDTH]
                   ? {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      orig_a_q <= '0;
      sa_q     <= 1'b0;
      neg_q    <= 1'b0;
      div_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      divz_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mcand_q  <= div_op ? abs_b : abs_a;
            acc_q    <= {{WIDTH{1'b0}}, (div_op ? abs_a : abs_b)};
            orig_a_q <= src_a;
            sa_q     <= signed_op & src_a[WIDTH-1];
            neg_q    <= signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            div_q    <= div_op;
            zero_q   <= div_op & b_zero;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            if (div_op && b_zero) state_q <= S_FIX;
            else if (div_op)      state_q <= S_DIV;
            else                  state_q <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= S_FIX;
        end
        S_DIV: begin
          acc_q <= div_acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= S_FIX;
        end
        default: begin
          if (zero_q) begin
            lo_q   <= '1;
            hi_q   <= orig_a_q;
            divz_q <= 1'b1;
          end else if (div_q) begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          zero_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign md_busy  = MD_EN & busy_q;
  assign md_done  = MD_EN & done_q;
  assign div_zero = MD_EN & divz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_alu_md_control.sv
// Bench for alu_md_control: decode sweep plus a scoreboard of mult/div results
// checked against a 64-bit arithmetic model when md_done pulses.
module tb_alu_md_control;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic          instr_valid;
  logic [1:0]    ALUOp;
  logic [5:0]    Funct;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic [2:0]    ALUControl;
  logic          illegal;
  logic          mf_sel;
  logic [W-1:0]  md_result;
  logic          md_stall;
  logic          md_busy;
  logic          md_done;
  logic          div_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  alu_md_control #(.WIDTH(W), .MD_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .ALUOp      (ALUOp),
    .Funct      (Funct),
    .src_a      (src_a),
    .src_b      (src_b),
    .ALUControl (ALUControl),
    .illegal    (illegal),
    .mf_sel     (mf_sel),
    .md_result  (md_result),
    .md_stall   (md_stall),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .div_zero   (div_zero),
    .hi         (hi),
    .lo         (lo)
  );

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   next_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void dec_model(input logic [5:0] f, output logic [2:0] ctl, output logic ill);
    ill = 1'b0;
    case (f)
      6'h20: ctl = 3'b010;
      6'h22: ctl = 3'b110;
      6'h24: ctl = 3'b000;
      6'h25: ctl = 3'b001;
      6'h2a: ctl = 3'b111;
      6'h26: ctl = 3'b011;
      6'h27: ctl = 3'b100;
      6'h2b: ctl = 3'b101;
      6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12: ctl = 3'b010;
      default: begin ctl = 3'b010; ill = 1'b1; end
    endcase
  endfunction

  function automatic void md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output exp_t e);
    longint      sp;
    logic [63:0] up;
    e.id = 0; e.cyc = 0; e.dz = 1'b0; e.hi = '0; e.lo = '0;
    case (f)
      6'h18: begin sp = longint'($signed(a)) * longint'($signed(b)); {e.hi, e.lo} = sp; end
      6'h19: begin up = {32'b0, a} * {32'b0, b}; {e.hi, e.lo} = up; end
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
        end else if (f == 6'h1a && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'd0;
        end else if (f == 6'h1a) begin
          e.lo = $signed(a) / $signed(b);
          e.hi = $signed(a) % $signed(b);
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
  endfunction

  // Scoreboard consumer: every md_done must match the oldest outstanding op.
  always @(negedge clk) begin
    if (rst_n && md_done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(md_done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("op%0d_hi", e.id), 64'(hi), 64'(e.hi));
        check($sformatf("op%0d_lo", e.id), 64'(lo), 64'(e.lo));
        check($sformatf("op%0d_div_zero", e.id), 64'(div_zero), 64'(e.dz));
        check($sformatf("op%0d_done_cycle", e.id), 64'(cyc), 64'(e.cyc));
        check($sformatf("op%0d_busy_low", e.id), 64'(md_busy), 64'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    exp_t e;
    int   lat;
    ALUOp = 2'b10; Funct = f; src_a = a; src_b = b; instr_valid = 1'b1;
    #1;
    stalls = 0;
    while (md_stall && stalls < 100) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stalls >= 100) check("accept_bound", 64'(stalls), 64'd0);
    md_model(f, a, b, e);
    lat   = e.dz ? 1 : W + 1;
    e.cyc = cyc + 1 + lat;
    e.id  = next_id++;
    sb.push_back(e);
    @(negedge clk);
    instr_valid = 1'b0; ALUOp = 2'b00; Funct = 6'h00;
    check($sformatf("op%0d_busy_after_accept", e.id), 64'(md_busy), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || md_busy) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("idle_bound", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [2:0]  ctl;
    logic        ill;
    logic [5:0]  f;
    logic [5:0]  ops [4];
    int          st;
    exp_t        ex;
    logic [31:0] ra, rb;

    ops[0] = 6'h18; ops[1] = 6'h19; ops[2] = 6'h1a; ops[3] = 6'h1b;
    instr_valid = 1'b0; ALUOp = 2'b00; Funct = 6'h00; src_a = '0; src_b = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(md_busy), 64'd0);
    check("rst_done", 64'(md_done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep with instr_valid low so nothing is accepted.
    ALUOp = 2'b00; #1; check("dec_op00", 64'({illegal, ALUControl}), 64'({1'b0, 3'b010}));
    ALUOp = 2'b01; #1; check("dec_op01", 64'({illegal, ALUControl}), 64'({1'b0, 3'b110}));
    ALUOp = 2'b11; #1; check("dec_op11", 64'({illegal, ALUControl}), 64'({1'b0, 3'b001}));
    ALUOp = 2'b10;
    for (int i = 0; i < 64; i++) begin
      f = 6'(i);
      Funct = f; #1;
      dec_model(f, ctl, ill);
      check($sformatf("dec_funct_%02h", f), 64'({illegal, ALUControl}), 64'({ill, ctl}));
    end
    Funct = 6'h10; #1;
    check("mf_sel_invalid", 64'(mf_sel), 64'd0);
    instr_valid = 1'b1; #1;
    check("mf_sel_mfhi", 64'(mf_sel), 64'd1);
    check("stall_idle", 64'(md_stall), 64'd0);
    Funct = 6'h20; #1;
    check("mf_sel_add", 64'(mf_sel), 64'd0);
    instr_valid = 1'b0; ALUOp = 2'b00;
    @(negedge clk);

    // Directed mult/div cases, including divide by zero and MIN / -1.
    issue(6'h18, 32'hFFFF_FFFD, 32'd7, st);          wait_idle();
    issue(6'h19, 32'hFFFF_FFFD, 32'd7, st);          wait_idle();
    issue(6'h1a, 32'hFFFF_FFF9, 32'd2, st);          wait_idle();
    issue(6'h1b, 32'd100, 32'd7, st);                wait_idle();
    issue(6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, st);  wait_idle();
    issue(6'h1a, 32'h0000_1234, 32'd0, st);          wait_idle();
    issue(6'h1b, 32'hDEAD_BEEF, 32'd0, st);          wait_idle();
    issue(6'h18, 32'h8000_0000, 32'h8000_0000, st);  wait_idle();

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      issue(ops[$urandom_range(0, 3)], ra, rb, st);
      wait_idle();
    end

    // MFLO right behind a MULT stalls until the result is written.
    issue(6'h18, 32'h1234_5678, 32'hFFFF_0001, st);
    md_model(6'h18, 32'h1234_5678, 32'hFFFF_0001, ex);
    ALUOp = 2'b10; Funct = 6'h12; instr_valid = 1'b1;
    #1;
    st = 0;
    while (md_stall && st < 100) begin
      @(negedge clk); #1;
      st++;
    end
    check("mflo_stall_cycles", 64'(st), 64'(W + 1));
    check("mflo_sel", 64'(mf_sel), 64'd1);
    check("mflo_done_same_cycle", 64'(md_done), 64'd1);
    check("mflo_result", 64'(md_result), 64'(ex.lo));
    Funct = 6'h10; #1;
    check("mfhi_result", 64'(md_result), 64'(ex.hi));
    @(negedge clk);
    instr_valid = 1'b0; ALUOp = 2'b00; Funct = 6'h00;
    wait_idle();

    // A second MULT issued mid-op is held then accepted when the first completes.
    issue(6'h19, 32'h0001_0003, 32'h0002_0005, st);
    issue(6'h18, 32'd5, 32'hFFFF_FFFD, st);
    check("mult2_stall_cycles", 64'(st), 64'(W + 1));
    wait_idle();

    // Asynchronous reset in the middle of a MULT.
    issue(6'h18, 32'h7654_3210, 32'h0BAD_F00D, st);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_busy", 64'(md_busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_done_quiet", 64'(md_done), 64'd0);
    issue(6'h1b, 32'd9, 32'd3, st);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
